// File: rtl/period_meter.sv
// period_meter: measures sig_in edge-to-edge intervals in clk_in cycles,
// flagging when consecutive measurements agree and when sig_in has stalled.
module period_meter #(
    parameter logic [24:0] TIMEOUT = 25'd20000000,
    parameter logic [24:0] TOL     = 25'd0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        en,
    input  logic        sig_in,
    output logic [24:0] half_period,
    output logic        valid,
    output logic        stable,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, COUNT, STALL} state_t;
    state_t state, state_d;
    logic s1, s2, hist, edge_pulse;
    logic prev_ok, prev_ok_d, valid_d, stable_d, timeout_d;
    logic [24:0] cnt, cnt_d, hp_d, meas, diff;
    assign edge_pulse = s2 ^ hist;
    assign meas = cnt + 25'd1;
    assign diff = meas >= half_period ? meas - half_period : half_period - meas;
    // The synchronizer ignores en so that raising en never shows a stale edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) {s1, s2, hist} <= 3'b000;
        else {s1, s2, hist} <= {sig_in, s1, s2};
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            cnt         <= '0;
            half_period <= '0;
            valid       <= 1'b0;
            stable      <= 1'b0;
            timeout     <= 1'b0;
            prev_ok     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            half_period <= hp_d;
            valid       <= valid_d;
            stable      <= stable_d;
            timeout     <= timeout_d;
            prev_ok     <= prev_ok_d;
        end
    end
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        hp_d      = half_period;
        valid_d   = 1'b0;
        stable_d  = stable;
        timeout_d = timeout;
        prev_ok_d = prev_ok;
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            stable_d  = 1'b0;
            timeout_d = 1'b0;
            prev_ok_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = edge_pulse ? COUNT : IDLE;
                end
                COUNT: begin
                    // An edge coinciding with the last counted cycle is a valid measurement
                    if (edge_pulse) begin
                        hp_d      = meas;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        stable_d  = prev_ok && (diff <= TOL);
                        prev_ok_d = 1'b1;
                    end else if (cnt == TIMEOUT - 25'd1) begin
                        state_d   = STALL;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        stable_d  = 1'b0;
                        prev_ok_d = 1'b0;
                    end else begin
                        cnt_d = meas;
                    end
                end
                STALL: begin
                    if (edge_pulse) begin
                        state_d   = COUNT;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed sig_in toggling, checked against an
// interval-based model of measurements, stability and stall timing.
module tb_period_meter;
    localparam int T  = 1000;
    localparam int TL = 3;
    typedef struct {
        int cyc;
        int val;
        bit stb;
    } vexp_t;
    logic        clk_in = 1'b0;
    logic        rst_n_in, en, sig_in;
    logic [24:0] half_period;
    logic        valid, stable, timeout;
    int checks = 0, failures = 0, cyc = 0;
    vexp_t exp_q[$];
    vexp_t me;
    int tq_exp[$], tq_obs[$];
    int gaps[$];
    bit armed, have_prev, stalled, to_prev;
    int prev, last_t;

    period_meter #(.TIMEOUT(25'(T)), .TOL(25'(TL))) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .en(en), .sig_in(sig_in),
        .half_period(half_period), .valid(valid), .stable(stable), .timeout(timeout)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Every valid pulse must match the oldest predicted measurement
    always @(negedge clk_in) begin
        if (valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid cyc=%0d half_period=%0d stable=%0b", cyc, half_period, stable);
            end else begin
                me = exp_q.pop_front();
                if (cyc !== me.cyc || half_period !== 25'(me.val) || stable !== me.stb) begin
                    failures++;
                    $display("FAIL valid_event got cyc=%0d hp=%0d stable=%0b want cyc=%0d hp=%0d stable=%0b",
                             cyc, half_period, stable, me.cyc, me.val, me.stb);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_valid got none want cyc=%0d hp=%0d", exp_q[0].cyc, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        if (timeout && !to_prev) tq_obs.push_back(cyc);
        to_prev = timeout;
    end

    function automatic void step(input int t);
        int g;
        vexp_t e;
        g = t - last_t;
        if (!armed) armed = 1;
        else if (stalled) stalled = 0;
        else if (g <= T) begin
            e.cyc = t + 3;
            e.val = g;
            e.stb = have_prev && ((g > prev ? g - prev : prev - g) <= TL);
            exp_q.push_back(e);
            prev = g;
            have_prev = 1;
        end else begin
            tq_exp.push_back(last_t + 3 + T);
            have_prev = 0;
        end
        last_t = t;
    endfunction

    function automatic void model_clear();
        armed = 0;
        have_prev = 0;
        stalled = 0;
    endfunction

    task automatic play();
        for (int i = 0; i < gaps.size(); i++) begin
            do @(negedge clk_in); while (cyc < last_t + gaps[i]);
            sig_in = ~sig_in;
            step(cyc);
        end
        gaps.delete();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b1;
        en = 1'b1;
        sig_in = 1'b0;
        #1 rst_n_in = 1'b0;
        model_clear();
        last_t = 0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({half_period, valid, stable, timeout} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outputs got hp=%0d v=%0b s=%0b t=%0b want all 0", half_period, valid, stable, timeout);
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            checks++;
            if ({half_period, valid, stable, timeout} !== 28'd0) begin
                failures++;
                $display("FAIL idle_outputs cyc=%0d got hp=%0d v=%0b s=%0b t=%0b want all 0", cyc, half_period, valid, stable, timeout);
            end
        end
    endtask

    task automatic test_basic();
        gaps = '{10, 100, 100, 100, 37, 37};
        play();
        repeat (6) @(negedge clk_in);
        checks++;
        if (half_period !== 25'd37 || stable !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_final got hp=%0d stable=%0b pending=%0d want hp=37 stable=1 pending=0", half_period, stable, exp_q.size());
        end
    endtask

    task automatic test_random();
        int base, g;
        base = $urandom_range(150, 20);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(2, 0) == 0) begin
                g = $urandom_range(200, 1);
                if (g >= 20) base = g;
            end else g = base + $urandom_range(6, 0) - 3;
            gaps.push_back(g);
        end
        play();
        repeat (6) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0 || tq_obs.size() != 0) begin
            failures++;
            $display("FAIL random_drain got pending=%0d timeouts=%0d want 0 0", exp_q.size(), tq_obs.size());
        end
    endtask

    task automatic test_back_to_back();
        gaps = '{1, 1, 1, 1, 2, 2, 3, 1};
        play();
        repeat (6) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0 || half_period !== 25'd1) begin
            failures++;
            $display("FAIL b2b_final got pending=%0d hp=%0d want 0 1", exp_q.size(), half_period);
        end
    endtask

    task automatic compare_timeouts(input string tag);
        for (int i = 0; i < tq_exp.size(); i++) begin
            checks++;
            if (i >= tq_obs.size() || tq_obs[i] != tq_exp[i]) begin
                failures++;
                $display("FAIL %s_rise%0d got cyc=%0d want cyc=%0d", tag, i, i < tq_obs.size() ? tq_obs[i] : -1, tq_exp[i]);
            end
        end
        checks++;
        if (tq_obs.size() != tq_exp.size()) begin
            failures++;
            $display("FAIL %s_rise_count got %0d want %0d", tag, tq_obs.size(), tq_exp.size());
        end
        tq_obs.delete();
        tq_exp.delete();
    endtask

    task automatic test_timeout();
        gaps = '{1000, 1000};
        play();
        repeat (1100) @(negedge clk_in);
        tq_exp.push_back(last_t + 3 + T);
        stalled = 1;
        have_prev = 0;
        checks++;
        if (timeout !== 1'b1 || half_period !== 25'd1000 || stable !== 1'b0) begin
            failures++;
            $display("FAIL stall_state got t=%0b hp=%0d s=%0b want t=1 hp=1000 s=0", timeout, half_period, stable);
        end
        compare_timeouts("stall");
        gaps = '{7, 80, 80};
        play();
        repeat (6) @(negedge clk_in);
        checks++;
        if (timeout !== 1'b0 || half_period !== 25'd80 || stable !== 1'b1) begin
            failures++;
            $display("FAIL stall_recover got t=%0b hp=%0d s=%0b want t=0 hp=80 s=1", timeout, half_period, stable);
        end
        gaps = '{1001, 90, 90};
        play();
        repeat (6) @(negedge clk_in);
        compare_timeouts("late_edge");
        checks++;
        if (timeout !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL late_edge_final got t=%0b pending=%0d want 0 0", timeout, exp_q.size());
        end
    endtask

    task automatic test_en_drop();
        logic [24:0] hp_saved;
        gaps = '{30, 30};
        play();
        repeat (10) @(negedge clk_in);
        hp_saved = half_period;
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL en_pre_stable got %0b want 1", stable);
        end
        en = 1'b0;
        @(negedge clk_in);
        checks++;
        if (valid !== 1'b0 || stable !== 1'b0 || timeout !== 1'b0 || half_period !== hp_saved) begin
            failures++;
            $display("FAIL en_drop got v=%0b s=%0b t=%0b hp=%0d want 0 0 0 hp=%0d", valid, stable, timeout, half_period, hp_saved);
        end
        en = 1'b1;
        model_clear();
        gaps = '{20, 40, 40};
        play();
        repeat (6) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0 || tq_obs.size() != 0 || half_period !== 25'd40) begin
            failures++;
            $display("FAIL en_rearm got pending=%0d timeouts=%0d hp=%0d want 0 0 40", exp_q.size(), tq_obs.size(), half_period);
        end
    endtask

    task automatic test_reset_mid();
        gaps = '{25, 25};
        play();
        repeat (10) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        sig_in = 1'b0;
        #1;
        checks++;
        if ({half_period, valid, stable, timeout} !== 28'd0) begin
            failures++;
            $display("FAIL mid_reset got hp=%0d v=%0b s=%0b t=%0b want all 0", half_period, valid, stable, timeout);
        end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        model_clear();
        gaps = '{15, 60, 60};
        play();
        repeat (6) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0 || tq_obs.size() != 0 || half_period !== 25'd60 || stable !== 1'b1) begin
            failures++;
            $display("FAIL reset_rearm got pending=%0d timeouts=%0d hp=%0d s=%0b want 0 0 60 1",
                     exp_q.size(), tq_obs.size(), half_period, stable);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_timeout();
        test_en_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 25'd20000000, which is the number of clk_in cycles without an edge that declares sig_in stalled.
REQ-002 SHALL have parameter TOL, default 25'd0, which is the maximum absolute difference between consecutive measurements that still counts as stable.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: measurement enable, synchronous.
REQ-006 SHALL have port sig_in, input, 1 bit: the square wave under test, asynchronous to clk_in.
REQ-007 SHALL have port half_period, output, 25 bits: the last measured edge-to-edge interval in clk_in cycles.
REQ-008 SHALL have port valid, output, 1 bit: a one-cycle pulse when half_period updates.
REQ-009 SHALL have port stable, output, 1 bit: a level meaning the last two measurements agree within TOL.
REQ-010 SHALL have port timeout, output, 1 bit: a level meaning no edge arrived within TIMEOUT cycles.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer followed by one history flop; edge_pulse = sync XOR history, so both rising and falling edges count.
REQ-012 SHALL produce edge_pulse exactly 3 clk_in cycles after a sig_in transition that meets setup time.
REQ-013 SHALL implement FSM states IDLE, COUNT and STALL, encoded in 2 bits.
REQ-014 IDLE: cnt held at 0; on edge_pulse with en=1, SHALL go to COUNT with cnt<=0 and no valid pulse, because the first edge has no reference.
REQ-015 COUNT: cnt SHALL increment by 1 per cycle; on edge_pulse, SHALL set half_period<=cnt+1, valid<=1 for one cycle, cnt<=0, and stay in COUNT.
REQ-016 Consequence: for a sig_in that toggles every N clk_in cycles, half_period SHALL equal N.
REQ-017 COUNT: when cnt == TIMEOUT-1 and there is no edge_pulse, SHALL go to STALL with timeout<=1 and stable<=0; half_period SHALL be retained.
REQ-018 If an edge_pulse occurs in the same cycle as cnt == TIMEOUT-1, the edge SHALL win: measurement TIMEOUT is reported, state stays COUNT, timeout stays 0.
REQ-019 STALL: on edge_pulse, SHALL set timeout<=0, cnt<=0 and go to COUNT with no valid pulse, since that edge restarts the reference.
REQ-020 cnt SHALL be 25 bits and can never exceed TIMEOUT-1, so there is no wrap-around.
REQ-021 TIMEOUT SHALL satisfy 2 <= TIMEOUT <= 2^25-1; other values are unsupported.
REQ-022 stable SHALL be updated only on a valid cycle: it is set to 1 if |new - previous| <= TOL, using 25-bit unsigned compare after ordering the operands, else 0.
REQ-023 The previous value used by REQ-022 SHALL be invalid after reset, en=0 or STALL, so the first valid after any of these SHALL set stable=0.
REQ-024 en=0 SHALL force IDLE on the next edge, with cnt=0, valid=0, stable=0 and timeout=0; half_period SHALL be retained.
REQ-025 en=0 SHALL take priority over edge_pulse and over the timeout condition.
REQ-026 The synchronizer SHALL keep running while en=0, so no false edge appears when en rises.
REQ-027 All outputs SHALL be driven directly from registers.

Reset
REQ-028 On rst_n_in=0, immediately and asynchronously: state=IDLE, cnt=0, half_period=0, valid=0, stable=0, timeout=0, previous-valid flag=0.
REQ-029 On rst_n_in=0, the synchronizer and history flops SHALL be set to 0.
REQ-030 Reset asserted mid-measurement SHALL discard the partial count; after release, the first edge only re-arms the block.
REQ-031 Deassertion SHALL be handled by the integrating top level.

Verification
REQ-032 Reset then en=1, sig_in=0 for 50 cycles -> all outputs 0, no valid, state IDLE.
REQ-033 sig_in toggles every 100 cycles -> first valid 3 cycles after the 2nd transition with half_period=100, stable=0; the next valid shows 100 with stable=1.
REQ-034 Period changes from 100 to 37, TOL=0 -> valid with 37 and stable=0, then valid with 37 and stable=1.
REQ-035 TIMEOUT=1000, sig_in frozen after an edge -> timeout=1 exactly 1000 cycles after that edge_pulse with half_period unchanged; the next transition clears timeout with no valid, and the following transition gives valid.
REQ-036 TIMEOUT=1000, toggle every 1000 cycles -> timeout never asserts and half_period=1000 on each valid (edge-wins boundary).
REQ-037 en dropped for 1 cycle, or rst_n_in pulsed, mid-count -> valid, stable and timeout go to 0, and re-arm needs two transitions before the next valid.
